// File: rtl/dff_stim_checker_if.sv
// Bundle between the stimulus/response checker and its user.
// master: the checker (drives stimulus and results).
// slave: the environment (drives enable, start and the DUT Q return).
interface dff_stim_checker_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             start;
  logic [7:0]       dut_d;
  logic [7:0]       dut_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [7:0]       fail_idx;
  logic [7:0]       fail_data;

  modport master (
    input  ena, start, dut_q,
    output dut_d, busy, done, pass, err_count, fail_idx, fail_data
  );

  modport slave (
    output ena, start, dut_q,
    input  dut_d, busy, done, pass, err_count, fail_idx, fail_data
  );
endinterface

// File: rtl/dff_stim_checker.sv
// BIST companion for a flip-flop DUT on an 8-bit port.
// An LFSR drives vectors on dut_d; a delay line of depth DUT_LATENCY+1
// holds expected values that are compared against dut_q.
// Optional first-failure capture: define DFF_CHECK_FIRST_FAIL_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs cleared since reset
// RUN   | issuing vectors v0..v(NUM_VECTORS-1)
// DRAIN | stimulus done, waiting for the last compares
// DONE  | results valid and held until next start
module dff_stim_checker #(
  parameter int         NUM_VECTORS = 16,
  parameter int         DUT_LATENCY = 1,
  parameter logic [7:0] SEED        = 8'h01,
  parameter int         CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dff_stim_checker_if.master    bus
);

  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int               DEPTH    = DUT_LATENCY + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [7:0]              lfsr;
  logic [7:0]              issue_left;
  logic [2:0]              drain_left;
  logic [7:0]              dut_d_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    pass_r;
  logic [CNT_W-1:0]        err_count_r;
  logic [DEPTH-1:0][7:0]   exp_data;
  logic [DEPTH-1:0]        exp_vld;

  logic       start_run;
  logic       push;
  logic [7:0] push_data;
  logic       cmp_en;
  logic       mismatch;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Issue and compare qualifiers for the current cycle.
  always_comb begin
    start_run = 1'b0;
    push      = 1'b0;
    push_data = lfsr;
    if ((state == IDLE || state == DONE) && bus.start) begin
      start_run = 1'b1;
      push      = 1'b1;
      push_data = SEED_EFF;
    end else if (state == RUN && issue_left != 8'd0) begin
      push = 1'b1;
    end
    cmp_en   = exp_vld[DEPTH-1];
    mismatch = cmp_en && (exp_data[DEPTH-1] != bus.dut_q);
  end

  // Expected-value delay line: each issued vector reaches the tail when dut_q should carry it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_vld  <= '0;
      exp_data <= '0;
    end else if (bus.ena) begin
      exp_vld  <= {exp_vld[DEPTH-2:0], push};
      exp_data <= {exp_data[DEPTH-2:0], push_data};
    end
  end

  // Sequencer FSM with registered stimulus, status and mismatch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= SEED_EFF;
      issue_left  <= 8'd0;
      drain_left  <= 3'd0;
      dut_d_r     <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= '0;
    end else if (bus.ena) begin
      if (mismatch && err_count_r != '1)
        err_count_r <= err_count_r + CNT_ONE;
      case (state)
        IDLE, DONE: begin
          if (start_run) begin
            state       <= RUN;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= '0;
            dut_d_r     <= SEED_EFF;
            lfsr        <= lfsr_step(SEED_EFF);
            issue_left  <= 8'(NUM_VECTORS - 1);
          end
        end
        RUN: begin
          if (issue_left != 8'd0) begin
            dut_d_r    <= lfsr;
            lfsr       <= lfsr_step(lfsr);
            issue_left <= issue_left - 8'd1;
          end else begin
            dut_d_r    <= 8'd0;
            drain_left <= 3'(DUT_LATENCY);
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_left == 3'd0) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_count_r == '0) && !mismatch;
          end else begin
            drain_left <= drain_left - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_d     = dut_d_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_count_r;

`ifdef DFF_CHECK_FIRST_FAIL_EN
  logic [7:0] cmp_idx;
  logic       fail_seen;
  logic [7:0] fail_idx_r;
  logic [7:0] fail_data_r;

  // Index of the compare in flight and a one-shot capture of the first mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_idx     <= 8'd0;
      fail_seen   <= 1'b0;
      fail_idx_r  <= 8'd0;
      fail_data_r <= 8'd0;
    end else if (bus.ena) begin
      if (start_run) begin
        cmp_idx     <= 8'd0;
        fail_seen   <= 1'b0;
        fail_idx_r  <= 8'd0;
        fail_data_r <= 8'd0;
      end else begin
        if (cmp_en)
          cmp_idx <= cmp_idx + 8'd1;
        if (mismatch && !fail_seen) begin
          fail_seen   <= 1'b1;
          fail_idx_r  <= cmp_idx;
          fail_data_r <= bus.dut_q;
        end
      end
    end
  end

  assign bus.fail_idx  = fail_idx_r;
  assign bus.fail_data = fail_data_r;
`else
  assign bus.fail_idx  = 8'd0;
  assign bus.fail_data = 8'd0;
`endif

endmodule

// File: tb/tb_dff_stim_checker.sv
// Self-checking bench for dff_stim_checker with a behavioural LFSR/compare model.
module tb_dff_stim_checker;
  localparam int         N    = 16;
  localparam int         L    = 1;
  localparam logic [7:0] SEED = 8'h01;
`ifdef DFF_CHECK_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dff_stim_checker_if #(.CNT_W(8)) bus();

  dff_stim_checker #(
    .NUM_VECTORS(N), .DUT_LATENCY(L), .SEED(SEED), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] vec [N];
  int         mode = 0;      // 0 ideal DFF, 1 stuck, 2 two DFFs, 3 glitch
  logic [7:0] stuck_val = 8'h00;
  logic [7:0] glitch_mask = 8'h01;
  int         glitch_k = 0;
  logic [7:0] q1, q2;

  // DUT models sharing the checker's enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 8'h00;
      q2 <= 8'h00;
    end else if (bus.ena) begin
      q1 <= bus.dut_d;
      q2 <= q1;
    end
  end

  assign bus.dut_q = (mode == 1) ? stuck_val :
                     (mode == 2) ? q2 :
                     (mode == 3 && q1 == vec[glitch_k]) ? (q1 ^ glitch_mask) : q1;

  function automatic logic [7:0] next_v(input logic [7:0] b);
    return {b[6:0], ^(b & 8'hB8)};
  endfunction

  task automatic build_model();
    logic [7:0] v;
    v = (SEED == 8'h00) ? 8'h01 : SEED;
    for (int k = 0; k < N; k++) begin
      vec[k] = v;
      v = next_v(v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.pass !== 1'b0 || bus.err_count !== 8'h00) begin
      errors++;
      $display("FAIL start_clear: busy=%b done=%b pass=%b err=%0h required 1 0 0 0",
               bus.busy, bus.done, bus.pass, bus.err_count);
    end
  endtask

  task automatic run_to_done(input bit chk_seq, input int pause_at, input int pause_len,
                             output int busy_n);
    int act;
    int cyc;
    bit en_prev;
    logic [7:0] exp_d;
    act = 1;
    cyc = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && cyc < 300) begin
      cyc++;
      if (bus.busy === 1'b1) busy_n++;
      if (chk_seq) begin
        exp_d = (act - 1 < N) ? vec[act-1] : 8'h00;
        checks++;
        if (bus.dut_d !== exp_d) begin
          errors++;
          $display("FAIL dut_d_seq[%0d]: got %0h required %0h", act - 1, bus.dut_d, exp_d);
        end
      end
      if (cyc == pause_at) bus.ena = 1'b0;
      if (cyc == pause_at + pause_len) bus.ena = 1'b1;
      en_prev = bus.ena;
      @(negedge clk);
      if (en_prev) act++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_reached: done=%b busy=%b after %0d cycles required 1 0",
               bus.done, bus.busy, cyc);
    end
    bus.ena = 1'b1;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1;
    bus.start = 1'b0;
    mode = 0;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus.dut_d, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_idx, bus.fail_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: d=%0h busy=%b done=%b pass=%b err=%0h fi=%0h fd=%0h required all 0",
               bus.dut_d, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_idx, bus.fail_data);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_d !== 8'h00) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b d=%0h required 0 0 0", bus.busy, bus.done, bus.dut_d);
    end
  endtask

  task automatic test_ideal();
    int busy_n;
    logic [7:0] known [8];
    known = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    mode = 0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.dut_d !== known[i]) begin
        errors++;
        $display("FAIL ideal_known_vec[%0d]: got %0h required %0h", i, bus.dut_d, known[i]);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    run_to_done(1'b1, 0, 0, busy_n);
    checks++;
    if (busy_n != N + L + 1) begin
      errors++;
      $display("FAIL ideal_busy_len: got %0d required %0d", busy_n, N + L + 1);
    end
    checks++;
    if (bus.pass !== 1'b1 || bus.err_count !== 8'h00 || bus.fail_idx !== 8'h00 || bus.fail_data !== 8'h00) begin
      errors++;
      $display("FAIL ideal_result: pass=%b err=%0h fi=%0h fd=%0h required 1 0 0 0",
               bus.pass, bus.err_count, bus.fail_idx, bus.fail_data);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.dut_d !== 8'h00) begin
      errors++;
      $display("FAIL done_hold: done=%b pass=%b d=%0h required 1 1 0", bus.done, bus.pass, bus.dut_d);
    end
  endtask

  task automatic test_stuck();
    int busy_n;
    int exp_err;
    int exp_idx;
    logic [7:0] vals [2];
    vals[0] = 8'h00;
    vals[1] = 8'($urandom_range(0, 255));
    for (int t = 0; t < 2; t++) begin
      stuck_val = vals[t];
      mode = 1;
      exp_err = 0;
      exp_idx = -1;
      for (int k = 0; k < N; k++)
        if (vec[k] != stuck_val) begin
          exp_err++;
          if (exp_idx < 0) exp_idx = k;
        end
      pulse_start();
      run_to_done(1'b0, 0, 0, busy_n);
      checks++;
      if (bus.err_count !== 8'(exp_err) || bus.pass !== (exp_err == 0)) begin
        errors++;
        $display("FAIL stuck_%0h_count: err=%0d pass=%b required %0d %b",
                 stuck_val, bus.err_count, bus.pass, exp_err, exp_err == 0);
      end
      checks++;
      if (bus.fail_idx !== ((FF_EN && exp_idx >= 0) ? 8'(exp_idx) : 8'h00) ||
          bus.fail_data !== ((FF_EN && exp_idx >= 0) ? stuck_val : 8'h00)) begin
        errors++;
        $display("FAIL stuck_%0h_first: fi=%0d fd=%0h required %0d %0h", stuck_val,
                 bus.fail_idx, bus.fail_data, (FF_EN && exp_idx >= 0) ? exp_idx : 0,
                 (FF_EN && exp_idx >= 0) ? stuck_val : 8'h00);
      end
    end
    mode = 0;
  endtask

  task automatic test_latency();
    int busy_n;
    int exp_err;
    int exp_idx;
    logic [7:0] seen;
    logic [7:0] exp_fd;
    mode = 2;
    exp_err = 0;
    exp_idx = -1;
    exp_fd = 8'h00;
    for (int k = 0; k < N; k++) begin
      seen = (k == 0) ? 8'h00 : vec[k-1];
      if (seen != vec[k]) begin
        exp_err++;
        if (exp_idx < 0) begin
          exp_idx = k;
          exp_fd = seen;
        end
      end
    end
    pulse_start();
    run_to_done(1'b0, 0, 0, busy_n);
    checks++;
    if (bus.err_count !== 8'(exp_err) || bus.pass !== 1'b0) begin
      errors++;
      $display("FAIL latency_count: err=%0d pass=%b required %0d 0", bus.err_count, bus.pass, exp_err);
    end
    checks++;
    if (bus.fail_idx !== (FF_EN ? 8'(exp_idx) : 8'h00) || bus.fail_data !== (FF_EN ? exp_fd : 8'h00)) begin
      errors++;
      $display("FAIL latency_first: fi=%0d fd=%0h required %0d %0h", bus.fail_idx, bus.fail_data,
               FF_EN ? exp_idx : 0, FF_EN ? exp_fd : 8'h00);
    end
    mode = 0;
  endtask

  task automatic test_glitch();
    int busy_n;
    int ks [2];
    logic [7:0] ms [2];
    ks[0] = 5;
    ms[0] = 8'h01;
    ks[1] = $urandom_range(0, N - 1);
    ms[1] = 8'h01 << $urandom_range(0, 7);
    for (int t = 0; t < 2; t++) begin
      glitch_k = ks[t];
      glitch_mask = ms[t];
      mode = 3;
      pulse_start();
      run_to_done(1'b0, 0, 0, busy_n);
      checks++;
      if (bus.err_count !== 8'h01 || bus.pass !== 1'b0) begin
        errors++;
        $display("FAIL glitch_k%0d_count: err=%0d pass=%b required 1 0", glitch_k, bus.err_count, bus.pass);
      end
      checks++;
      if (bus.fail_idx !== (FF_EN ? 8'(glitch_k) : 8'h00) ||
          bus.fail_data !== (FF_EN ? (vec[glitch_k] ^ glitch_mask) : 8'h00)) begin
        errors++;
        $display("FAIL glitch_k%0d_first: fi=%0d fd=%0h required %0d %0h", glitch_k,
                 bus.fail_idx, bus.fail_data, FF_EN ? glitch_k : 0,
                 FF_EN ? (vec[glitch_k] ^ glitch_mask) : 8'h00);
      end
    end
    mode = 0;
  endtask

  task automatic test_pause();
    int busy_n;
    int at;
    mode = 0;
    at = $urandom_range(3, 12);
    pulse_start();
    run_to_done(1'b1, at, 3, busy_n);
    checks++;
    if (busy_n != N + L + 1 + 3) begin
      errors++;
      $display("FAIL pause_busy_len: got %0d required %0d", busy_n, N + L + 4);
    end
    checks++;
    if (bus.pass !== 1'b1 || bus.err_count !== 8'h00) begin
      errors++;
      $display("FAIL pause_result: pass=%b err=%0d required 1 0", bus.pass, bus.err_count);
    end
  endtask

  task automatic test_abort();
    int busy_n;
    mode = 1;
    stuck_val = 8'h00;
    pulse_start();
    repeat ($urandom_range(3, 10)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dut_d, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_idx, bus.fail_data} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: d=%0h busy=%b done=%b pass=%b err=%0h fi=%0h fd=%0h required all 0",
               bus.dut_d, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_idx, bus.fail_data);
    end
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    pulse_start();
    run_to_done(1'b1, 0, 0, busy_n);
    checks++;
    if (bus.pass !== 1'b1 || bus.err_count !== 8'h00 || busy_n != N + L + 1) begin
      errors++;
      $display("FAIL abort_rerun: pass=%b err=%0d busy_len=%0d required 1 0 %0d",
               bus.pass, bus.err_count, busy_n, N + L + 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    test_reset();
    test_ideal();
    test_stuck();
    test_ideal();
    test_latency();
    test_glitch();
    test_pause();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_stim_checker.md
Name: dff_stim_checker

Overview:
- Self-checking stimulus and response block for a flip-flop-based device under test (DUT) sitting on the 8-bit dedicated I/O of a user project.
- Drives pseudo-random 8-bit vectors into the DUT's D input, samples the DUT's Q output after the configured latency, compares against the expected vector and counts mismatches.
- Used as an on-chip BIST (built-in self-test) companion to the DFF project and as a reusable bench component.

Parameters:
- NUM_VECTORS, 16: vectors issued per run; legal range 1..255.
- DUT_LATENCY, 1: DUT clock edges from D to Q; legal range 1..4.
- SEED, 8'h01: initial LFSR state; a value of 0 is replaced by 8'h01.
- CNT_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block clock-enable; when 0, all state holds. The DUT must share this enable.
- start  in  1  run request; sampled only in IDLE or DONE.
- dut_d  out  8  stimulus to the DUT D input, registered.
- dut_q  in  8  DUT Q output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid in DONE; 1 iff err_count == 0.
- err_count  out  CNT_W  mismatch count; saturates at all-ones.
- fail_idx  out  8  index of the first mismatching vector (optional feature).
- fail_data  out  8  dut_q value at the first mismatch (optional feature).

Behaviour:
- Reset (async, rst_n=0) forces all outputs and internal state to 0. The LFSR resets to SEED.
- LFSR:
  - 8-bit Fibonacci LFSR; shifts left.
  - new bit0 = b7^b5^b4^b3 (polynomial x^8+x^6+x^5+x^4+1, period 255).
  - v0 = SEED; v(i+1) = step(v(i)).
- States: IDLE, RUN, DRAIN, DONE. All transitions are qualified by ena=1.
- IDLE or DONE with start=1, at edge s:
  - Go to RUN.
  - Clear err_count, done, pass, fail_idx and fail_data.
  - dut_d <= v0; issue index = 0.
- RUN:
  - At edge s+i, dut_d <= v(i), for i = 0..NUM_VECTORS-1.
  - Each issued vector enters an expected-value delay line of depth DUT_LATENCY+1, with a valid bit.
  - start is ignored.
  - After issuing v(NUM_VECTORS-1), go to DRAIN; dut_d <= 0 at edge s+NUM_VECTORS.
- Compare:
  - v(k) is compared with dut_q at edge s+k+DUT_LATENCY+1, only when the delay-line valid bit is set.
  - On mismatch, err_count increments (saturating).
  - Equal means all 8 bits match.
- DRAIN:
  - Stays until the last compare at edge s+NUM_VECTORS+DUT_LATENCY.
  - Then goes to DONE at the next edge: done=1, busy=0, pass = (err_count == 0).
- DONE:
  - done, pass, err_count and fail fields hold until the next start or reset.
  - dut_d = 0.
- ena=0: no state, counter, delay line or output change; resumes exactly where it stopped.
- Reset mid-run: immediate return to IDLE with all outputs 0. No done pulse and no partial result is retained.
- busy and done are never high together. pass=0 whenever done=0.

Optional Feature:
- Macro: DFF_CHECK_FIRST_FAIL_EN.
- Defined: on the first mismatch of a run, fail_idx <= k (the vector index) and fail_data <= dut_q. Both stay frozen for the rest of the run. If there is no mismatch, both stay 0.
- Undefined: fail_idx and fail_data are tied to 0 and no capture logic exists. The ports remain present.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> dut_d, busy, done, pass, err_count, fail_idx and fail_data all 0 immediately, without waiting for a clock edge.
- Ideal loopback: DUT = one DFF, NUM_VECTORS=16, DUT_LATENCY=1, start pulse at edge s -> dut_d sequence 01,02,04,08,11,23,47,8E..., busy for 18 cycles, done=1 after edge s+18, pass=1, err_count=0.
- Stuck output: dut_q forced to 8'h00 -> err_count=16 (the LFSR is never 0), pass=0. With the macro defined, fail_idx=0 and fail_data=8'h00.
- Latency mismatch: DUT = two chained DFFs while DUT_LATENCY=1 -> every compare fails, err_count=16, pass=0.
- Single glitch: bit 0 of dut_q flipped only during the compare of vector 5 -> err_count=1, pass=0. With the macro defined, fail_idx=5 and fail_data=v5^8'h01.
- Pause and abort:
  - ena=0 for 3 cycles mid-RUN, with the DUT enable also gated -> results are identical to the ideal loopback; done is 3 cycles later.
  - rst_n pulse mid-RUN, then start -> clean run, pass=1.
